// File: rtl/draw_engine.sv
// ============================================================================
// Module   : draw_engine
// Purpose  : Pixel generator for Bresenham lines, filled rectangles and
//            full-screen clear. One pixel is emitted per cycle toward a
//            frame-buffer adapter. Define DRAW_ENGINE_CLIP_EN to suppress
//            writes that fall outside SCREEN_W x SCREEN_H.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x1,
  input  logic [X_W-1:0]     x2,
  input  logic [Y_W-1:0]     y1,
  input  logic [Y_W-1:0]     y2,
  input  logic [COLOR_W-1:0] input_color,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color,
  output logic               write_out,
  output logic               busy,
  output logic               done
);

  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_LINE  = 3'd2;
  localparam logic [2:0] S_RECT  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] M_LINE  = 2'd0;
  localparam logic [1:0] M_RECT  = 2'd1;
  localparam logic [1:0] M_CLEAR = 2'd2;

  localparam logic signed [CW-1:0] C_ZERO  = '0;
  localparam logic signed [CW-1:0] C_ONE   = CW'(1);
  localparam logic signed [CW-1:0] C_XLAST = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] C_YLAST = CW'(SCREEN_H - 1);

  logic [2:0]                state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [X_W-1:0]            x1_q, x1_d, x2_q, x2_d;
  logic [Y_W-1:0]            y1_q, y1_d, y2_q, y2_d;
  logic [COLOR_W-1:0]        color_q, color_d;
  logic signed [CW-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic signed [CW-1:0]      dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                      sxn_q, sxn_d, syn_q, syn_d;
  logic signed [CW-1:0]      xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [CW-1:0]      ymin_q, ymin_d, ymax_q, ymax_d;

  // Latched endpoints widened to the signed working width.
  logic signed [CW-1:0]      w_ex1, w_ex2, w_ey1, w_ey2;
  logic signed [CW-1:0]      w_ddx, w_ddy;
  logic signed [CW:0]        w_e2, w_dx_x, w_dy_x;
  logic                      w_xstep, w_ystep;
  logic                      w_active;
  logic                      w_unused;

  assign w_ex1  = {{(CW-X_W){1'b0}}, x1_q};
  assign w_ex2  = {{(CW-X_W){1'b0}}, x2_q};
  assign w_ey1  = {{(CW-Y_W){1'b0}}, y1_q};
  assign w_ey2  = {{(CW-Y_W){1'b0}}, y2_q};
  assign w_ddx  = w_ex2 - w_ex1;
  assign w_ddy  = w_ey2 - w_ey1;

  // e2 = 2*err is evaluated one bit wider so the doubling can never overflow.
  assign w_e2    = {err_q[CW-1], err_q} <<< 1;
  assign w_dx_x  = {dx_q[CW-1], dx_q};
  assign w_dy_x  = {dy_q[CW-1], dy_q};
  assign w_xstep = (w_e2 > -w_dy_x);
  assign w_ystep = (w_e2 < w_dx_x);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          x1_d    = x1;
          x2_d    = x2;
          y1_d    = y1;
          y2_d    = y2;
          color_d = input_color;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        case (mode_q)
          M_LINE: begin
            cx_d    = w_ex1;
            cy_d    = w_ey1;
            dx_d    = (w_ddx < C_ZERO) ? -w_ddx : w_ddx;
            dy_d    = (w_ddy < C_ZERO) ? -w_ddy : w_ddy;
            sxn_d   = (w_ddx < C_ZERO);
            syn_d   = (w_ddy < C_ZERO);
            err_d   = ((w_ddx < C_ZERO) ? -w_ddx : w_ddx)
                    - ((w_ddy < C_ZERO) ? -w_ddy : w_ddy);
            state_d = S_LINE;
          end
          M_RECT: begin
            xmin_d  = (w_ex1 < w_ex2) ? w_ex1 : w_ex2;
            xmax_d  = (w_ex1 < w_ex2) ? w_ex2 : w_ex1;
            ymin_d  = (w_ey1 < w_ey2) ? w_ey1 : w_ey2;
            ymax_d  = (w_ey1 < w_ey2) ? w_ey2 : w_ey1;
            cx_d    = (w_ex1 < w_ex2) ? w_ex1 : w_ex2;
            cy_d    = (w_ey1 < w_ey2) ? w_ey1 : w_ey2;
            state_d = S_RECT;
          end
          M_CLEAR: begin
            cx_d    = C_ZERO;
            cy_d    = C_ZERO;
            state_d = S_CLEAR;
          end
          default: state_d = S_DONE;
        endcase
      end

      S_LINE: begin
        if ((cx_q == w_ex2) && (cy_q == w_ey2)) begin
          state_d = S_DONE;
        end else begin
          err_d = err_q - (w_xstep ? dy_q : C_ZERO) + (w_ystep ? dx_q : C_ZERO);
          if (w_xstep) cx_d = sxn_q ? (cx_q - C_ONE) : (cx_q + C_ONE);
          if (w_ystep) cy_d = syn_q ? (cy_q - C_ONE) : (cy_q + C_ONE);
        end
      end

      S_RECT: begin
        if (cx_q == xmax_q) begin
          cx_d = xmin_q;
          if (cy_q == ymax_q) state_d = S_DONE;
          else                cy_d    = cy_q + C_ONE;
        end else begin
          cx_d = cx_q + C_ONE;
        end
      end

      S_CLEAR: begin
        if (cx_q == C_XLAST) begin
          cx_d = C_ZERO;
          if (cy_q == C_YLAST) state_d = S_DONE;
          else                 cy_d    = cy_q + C_ONE;
        end else begin
          cx_d = cx_q + C_ONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
    end
  end

  // The current coordinate register is the pixel being presented this cycle.
  assign w_active = (state_q == S_LINE) || (state_q == S_RECT) || (state_q == S_CLEAR);
  assign x_out    = cx_q[X_W-1:0];
  assign y_out    = cy_q[Y_W-1:0];
  assign color    = color_q;
  assign busy     = w_active || (state_q == S_INIT);
  assign done     = (state_q == S_DONE);
  assign w_unused = ^{cx_q[CW-1:X_W], cy_q[CW-1:Y_W]};

`ifdef DRAW_ENGINE_CLIP_EN
  assign write_out = w_active && (cx_q <= C_XLAST) && (cy_q <= C_YLAST);
`else
  assign write_out = w_active;
`endif

endmodule

`default_nettype wire

// File: tb/tb_draw_engine.sv
// ============================================================================
// Module   : tb_draw_engine
// Purpose  : Scoreboard bench for draw_engine: stimulus queues expected
//            pixels, a negedge monitor pops and compares every write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_engine;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef logic [X_W+Y_W+C_W-1:0] px_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [X_W-1:0] x1, x2;
  logic [Y_W-1:0] y1, y2;
  logic [C_W-1:0] input_color;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [C_W-1:0] color;
  logic           write_out, busy, done;

  always #5 clk = ~clk;

  draw_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .x1(x1), .x2(x2), .y1(y1), .y2(y2), .input_color(input_color),
    .x_out(x_out), .y_out(y_out), .color(color),
    .write_out(write_out), .busy(busy), .done(done)
  );

  px_t exp_q[$];
  px_t e_px;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  first_wr_cyc = -1;
  int  st_cyc = 0;
  int  done_cyc = 0;
  int  d0 = 0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, got, got, want, want, cyc);
    end
  endtask

  function automatic void push_px(input int x, input int y, input int c);
    exp_q.push_back({x[X_W-1:0], y[Y_W-1:0], c[C_W-1:0]});
  endfunction

  // Monitor: every write strobe consumes one expected pixel.
  always @(negedge clk) begin
    if (write_out === 1'b1) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_pixel: got (%0d,%0d) colour %0d, expected no write", x_out, y_out, color);
      end else begin
        e_px = exp_q.pop_front();
        check("pixel", {x_out, y_out, color}, e_px);
      end
    end
`ifndef DRAW_ENGINE_CLIP_EN
    if (prev_wr && busy === 1'b1) check("no_gap", write_out, 1);
`endif
    if (done === 1'b1) begin
      done_cnt++;
      check("done_busy_low", busy, 0);
      check("done_drained", exp_q.size(), 0);
    end
    if (prev_done) check("done_one_cycle", done, 0);
    prev_wr   = (write_out === 1'b1);
    prev_done = (done === 1'b1);
  end

  task automatic launch(input int m, input int ax, input int ay, input int bx, input int by, input int c);
    @(negedge clk);
    mode = m[1:0]; x1 = ax[X_W-1:0]; y1 = ay[Y_W-1:0];
    x2 = bx[X_W-1:0]; y2 = by[Y_W-1:0]; input_color = c[C_W-1:0];
    start = 1'b1;
    st_cyc = cyc;
    first_wr_cyc = -1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input bit pulses);
    bit timeout;
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        timeout = 1'b0;
        done_cyc = cyc;
        break;
      end
      if (pulses && (i % 1000 == 500)) begin
        start = 1'b1; mode = 2'd0; x1 = 8'd7; y1 = 7'd7; input_color = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (timeout) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0;
    x1 = '0; x2 = '0; y1 = '0; y2 = '0; input_color = '0;
    repeat (3) @(negedge clk);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_color", color, 0);
    check("rst_write", write_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    // Shallow line (0,0)->(5,2)
    push_px(0,0,4); push_px(1,0,4); push_px(2,1,4);
    push_px(3,1,4); push_px(4,2,4); push_px(5,2,4);
    launch(0, 0, 0, 5, 2, 4);
    wait_done(50, 1'b0);
    check("line_first_latency", first_wr_cyc - st_cyc, 2);
    check("line_done_cycle", done_cyc - st_cyc, 8);

    // Steep reversed line (4,9)->(2,3)
    push_px(4,9,6); push_px(4,8,6); push_px(3,7,6); push_px(3,6,6);
    push_px(3,5,6); push_px(2,4,6); push_px(2,3,6);
    launch(0, 4, 9, 2, 3, 6);
    wait_done(50, 1'b0);

    // Rectangle with swapped corners
    push_px(1,1,2); push_px(2,1,2); push_px(3,1,2);
    push_px(1,2,2); push_px(2,2,2); push_px(3,2,2);
    launch(1, 3, 2, 1, 1, 2);
    wait_done(50, 1'b0);

    // Degenerate line and rectangle
    push_px(7,7,5);
    launch(0, 7, 7, 7, 7, 5);
    wait_done(20, 1'b0);
    push_px(9,4,3);
    launch(1, 9, 4, 9, 4, 3);
    wait_done(20, 1'b0);

    // Reserved mode: no pixels, single done
    launch(3, 1, 1, 4, 4, 7);
    wait_done(20, 1'b0);

    // Clear screen with start pulses while busy
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        push_px(x, y, 7);
    launch(2, 3, 3, 4, 4, 7);
    wait_done(20000, 1'b1);
    check("clear_cycles", done_cyc - st_cyc, 19202);

    // Line crossing the right screen edge
`ifdef DRAW_ENGINE_CLIP_EN
    for (int x = 155; x <= 159; x++) push_px(x, 0, 1);
`else
    for (int x = 155; x <= 165; x++) push_px(x, 0, 1);
`endif
    launch(0, 155, 0, 165, 0, 1);
    wait_done(50, 1'b0);
    check("edge_line_cycles", done_cyc - st_cyc, 13);

    // Reset on the 4th pixel of a line
    push_px(0,0,2); push_px(1,0,2); push_px(2,0,2); push_px(3,0,2);
    launch(0, 0, 0, 10, 0, 2);
    repeat (4) @(negedge clk);
    check("abort_4th_write", write_out, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_write_low", write_out, 0);
    check("abort_busy_low", busy, 0);
    check("abort_no_done", done_cnt - d0, 0);
    reset = 1'b0;
    push_px(9,9,5);
    mode = 2'd0; x1 = 8'd9; y1 = 7'd9; x2 = 8'd9; y2 = 7'd9; input_color = 3'd5;
    start = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", busy, 1);
    wait_done(20, 1'b0);

    // start coincident with reset is ignored
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mode = 2'd1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
